// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: signed byte-stream sequencer wrapped around an unsigned restoring divider.
// Optional macro DIV_TRIVIAL_BYPASS_EN skips the divider when |divisor|==1 or dividend==0.
module div_seq_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       div_start,
    output logic [7:0] div_a,
    output logic [7:0] div_b,
    input  logic [7:0] div_q,
    input  logic [7:0] div_r,
    input  logic       div_done,
    output logic [7:0] res_q,
    output logic [7:0] res_r,
    output logic [1:0] res_err,
    output logic       out_valid,
    input  logic       out_ready
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD_B, S_CHECK, S_WAIT, S_FIX, S_OUT} state_t;

    localparam logic [1:0] ERR_OK   = 2'b00;
    localparam logic [1:0] ERR_DIV0 = 2'b01;
    localparam logic [1:0] ERR_OPND = 2'b10;
    localparam logic [1:0] ERR_TMO  = 2'b11;
    // WAIT lasts TIMEOUT_CYC cycles; the last one is where the counter reaches the limit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic             s1_q, s1_d, s2_q, s2_d;
    logic             bad_q, bad_d;
    logic [7:0]       mag_a_q, mag_a_d, mag_b_q, mag_b_d;
    logic [7:0]       quo_q, quo_d, rem_q, rem_d;
    logic [7:0]       rq_q, rq_d, rr_q, rr_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;

    function automatic logic [7:0] neg8(input logic [7:0] v);
        return ~v + 8'd1;
    endfunction

    function automatic logic [7:0] mag8(input logic [7:0] v);
        return v[7] ? neg8(v) : v;
    endfunction

    assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD_B);
    assign out_valid = (state_q == S_OUT);
    assign xfer      = in_valid && in_ready;
    assign div_a     = mag_a_q;
    assign div_b     = mag_b_q;
    assign res_q     = rq_q;
    assign res_r     = rr_q;
    assign res_err   = err_q;

    always_comb begin
        state_d   = state_q;
        s1_d      = s1_q;
        s2_d      = s2_q;
        bad_d     = bad_q;
        mag_a_d   = mag_a_q;
        mag_b_d   = mag_b_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        rq_d      = rq_q;
        rr_d      = rr_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        div_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (xfer) begin
                    s1_d    = in_data[7];
                    mag_a_d = mag8(in_data);
                    bad_d   = (in_data == 8'h80);
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (xfer) begin
                    s2_d    = in_data[7];
                    mag_b_d = mag8(in_data);
                    bad_d   = bad_q || (in_data == 8'h80);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_q) begin
                    err_d   = ERR_OPND;
                    rq_d    = 8'd0;
                    rr_d    = 8'd0;
                    state_d = S_OUT;
                end else if (mag_b_q == 8'd0) begin
                    err_d   = ERR_DIV0;
                    rq_d    = 8'd0;
                    rr_d    = 8'd0;
                    state_d = S_OUT;
`ifdef DIV_TRIVIAL_BYPASS_EN
                end else if (mag_b_q == 8'd1) begin
                    quo_d   = mag_a_q;
                    rem_d   = 8'd0;
                    state_d = S_FIX;
                end else if (mag_a_q == 8'd0) begin
                    quo_d   = 8'd0;
                    rem_d   = 8'd0;
                    state_d = S_FIX;
`endif
                end else begin
                    div_start = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (div_done) begin
                    quo_d   = div_q;
                    rem_d   = div_r;
                    state_d = S_FIX;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = ERR_TMO;
                    rq_d    = 8'd0;
                    rr_d    = 8'd0;
                    state_d = S_OUT;
                end
            end
            S_FIX: begin
                // Truncated division: remainder follows the dividend's sign.
                rq_d    = (s1_q ^ s2_q) ? neg8(quo_q) : quo_q;
                rr_d    = s1_q ? neg8(rem_q) : rem_q;
                err_d   = ERR_OK;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            bad_q   <= 1'b0;
            mag_a_q <= 8'd0;
            mag_b_q <= 8'd0;
            quo_q   <= 8'd0;
            rem_q   <= 8'd0;
            rq_q    <= 8'd0;
            rr_q    <= 8'd0;
            err_q   <= ERR_OK;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            bad_q   <= bad_d;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            rq_q    <= rq_d;
            rr_q    <= rr_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: directed and random signed divisions against an
// integer-arithmetic reference; the bench itself plays the role of the divider.
module tb_div_seq_ctrl;
    localparam int TMO = 16;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       div_start;
    logic [7:0] div_a;
    logic [7:0] div_b;
    logic [7:0] div_q;
    logic [7:0] div_r;
    logic       div_done;
    logic [7:0] res_q;
    logic [7:0] res_r;
    logic [1:0] res_err;
    logic       out_valid;
    logic       out_ready;

    int errors = 0;
    int checks = 0;

    div_seq_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .div_start(div_start), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_done(div_done),
        .res_q(res_q), .res_r(res_r), .res_err(res_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction. t counts negedges after the divisor transfer edge (t=1 is CHECK).
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int lat,
                          input bit hang, input int hold, input string tag);
        int sa, sb, ma, mb, t, done_at, starts, exp_t, exp_starts;
        logic [7:0] eq, er;
        logic [1:0] ee;
        bit byp;
        sa = $signed(a);
        sb = $signed(b);
        ma = (sa < 0) ? -sa : sa;
        mb = (sb < 0) ? -sb : sb;
        byp = 1'b0;
        if (sa == -128 || sb == -128) begin
            ee = 2'd2; eq = 8'd0; er = 8'd0; exp_starts = 0; exp_t = 2;
        end else if (sb == 0) begin
            ee = 2'd1; eq = 8'd0; er = 8'd0; exp_starts = 0; exp_t = 2;
        end else begin
`ifdef DIV_TRIVIAL_BYPASS_EN
            byp = (mb == 1) || (sa == 0);
`endif
            if (hang && !byp) begin
                ee = 2'd3; eq = 8'd0; er = 8'd0; exp_starts = 1; exp_t = TMO + 2;
            end else begin
                ee = 2'd0; eq = 8'(sa / sb); er = 8'(sa % sb);
                exp_starts = byp ? 0 : 1;
                exp_t = byp ? 3 : lat + 3;
            end
        end

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = a;
        chk({tag, "/rdy_a"}, 16'(in_ready), 16'd1);
        @(negedge clk);
        in_data = b;
        chk({tag, "/rdy_b"}, 16'(in_ready), 16'd1);
        @(negedge clk);
        in_valid = 1'b0;

        t = 1;
        starts = 0;
        done_at = -1;
        while (out_valid !== 1'b1 && t < 40) begin
            if (div_start === 1'b1) begin
                starts++;
                chk({tag, "/div_a"}, 16'(div_a), 16'(ma));
                chk({tag, "/div_b"}, 16'(div_b), 16'(mb));
                if (!hang) done_at = t + lat;
            end
            if (t == done_at) begin
                div_done = 1'b1;
                div_q = 8'(ma / mb);
                div_r = 8'(ma % mb);
            end else begin
                div_done = 1'b0;
            end
            @(negedge clk);
            t++;
        end
        div_done = 1'b0;

        chk({tag, "/out_valid"}, 16'(out_valid), 16'd1);
        chk({tag, "/latency"}, 16'(t), 16'(exp_t));
        chk({tag, "/starts"}, 16'(starts), 16'(exp_starts));
        chk({tag, "/res_q"}, 16'(res_q), 16'(eq));
        chk({tag, "/res_r"}, 16'(res_r), 16'(er));
        chk({tag, "/res_err"}, 16'(res_err), 16'(ee));
        chk({tag, "/busy_rdy"}, 16'(in_ready), 16'd0);

        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, "/hold_valid"}, 16'(out_valid), 16'd1);
            chk({tag, "/hold_q"}, 16'(res_q), 16'(eq));
            chk({tag, "/hold_r"}, 16'(res_r), 16'(er));
            chk({tag, "/hold_err"}, 16'(res_err), 16'(ee));
            chk({tag, "/hold_rdy"}, 16'(in_ready), 16'd0);
        end

        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "/drop_valid"}, 16'(out_valid), 16'd0);
        chk({tag, "/rdy_again"}, 16'(in_ready), 16'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "/in_ready"}, 16'(in_ready), 16'd1);
        chk({tag, "/div_start"}, 16'(div_start), 16'd0);
        chk({tag, "/div_a"}, 16'(div_a), 16'd0);
        chk({tag, "/div_b"}, 16'(div_b), 16'd0);
        chk({tag, "/res_q"}, 16'(res_q), 16'd0);
        chk({tag, "/res_r"}, 16'(res_r), 16'd0);
        chk({tag, "/res_err"}, 16'(res_err), 16'd0);
        chk({tag, "/out_valid"}, 16'(out_valid), 16'd0);
    endtask

    initial begin
        bit seen;
        logic [7:0] ra, rb;
        rst = 1'b0;
        in_data = 8'd0;
        in_valid = 1'b0;
        div_q = 8'd0;
        div_r = 8'd0;
        div_done = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("por");
        rst = 1'b1;
        @(negedge clk);

        // Directed cases from the plan plus operand-screen priority and the timeout boundary.
        run_op(8'd100, 8'd7,   3,  1'b0, 0, "p100_7");
        run_op(8'h9C,  8'd7,   5,  1'b0, 0, "m100_7");
        run_op(8'h9C,  8'hF9,  2,  1'b0, 0, "m100_m7");
        run_op(8'd50,  8'd0,   1,  1'b0, 0, "div0");
        run_op(8'h80,  8'd3,   1,  1'b0, 0, "opnd_a");
        run_op(8'd3,   8'h80,  1,  1'b0, 0, "opnd_b");
        run_op(8'h80,  8'd0,   1,  1'b0, 0, "opnd_pri");
        run_op(8'd20,  8'd3,   1,  1'b1, 0, "timeout");
        run_op(8'd20,  8'd3,   TMO, 1'b0, 0, "done_at_limit");
        run_op(8'd37,  8'hFB,  4,  1'b0, 5, "hold5");
        run_op(8'hF6,  8'd1,   2,  1'b0, 0, "by_one");
        run_op(8'd0,   8'hF3,  2,  1'b0, 0, "zero_dvd");
        run_op(8'd5,   8'd9,   1,  1'b0, 0, "small");

        // Reset while the divider is running; a late div_done must not produce a result.
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'd20;
        @(negedge clk);
        in_data = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rst_wait/start", 16'(div_start), 16'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_vals("rst_wait");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        div_done = 1'b1;
        div_q = 8'd6;
        div_r = 8'd2;
        @(negedge clk);
        div_done = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0 || div_start !== 1'b0) seen = 1'b1;
            @(negedge clk);
        end
        chk("late_done/no_result", 16'(seen), 16'd0);
        chk_reset_vals("late_done");

        // Reset after only the dividend: the partial operand must be forgotten.
        @(negedge clk);
        in_valid = 1'b1;
        in_data = 8'd5;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(8'd9, 8'd2, 2, 1'b0, 0, "after_partial");

        for (int i = 0; i < 30; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            case ($urandom_range(0, 9))
                0: rb = 8'd0;
                1: ra = 8'h80;
                2: rb = 8'h80;
                3: rb = ($urandom_range(0, 1) == 1) ? 8'h01 : 8'hFF;
                4: ra = 8'd0;
                default: ;
            endcase
            run_op(ra, rb, int'($urandom_range(1, TMO)), 1'b0,
                   int'($urandom_range(0, 2)), "rnd");
        end
        for (int i = 0; i < 3; i++) begin
            ra = 8'($urandom_range(1, 127));
            rb = 8'($urandom_range(2, 127));
            run_op(ra, rb, 1, 1'b1, 0, "rnd_tmo");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
